// File: rtl/sparse_pe_lanes.sv
// Sparse-CNN PE: one weight x up to LANES features per beat, scatter-accumulate into an OUTxOUT plane, raster drain.
// Latency: beat at edge t -> stage-1 at t -> accumulator at t+1; drain starts two cycles after the last beat.
// Backpressure: in_ready only in ACCUM; drain holds data_out/out_row/out_col while out_ready=0. Optional SPE_SATURATE_EN.
module sparse_pe_lanes #(
    parameter int LANES  = 4,
    parameter int COL_W  = 8,
    parameter int WORD_W = 8,
    parameter int ACC_W  = 20,
    parameter int KERNEL = 5,
    parameter int IMAGE  = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [WORD_W-1:0]         weight_value,
    input  logic [COL_W-1:0]          weight_rows,
    input  logic [COL_W-1:0]          weight_cols,
    input  logic [LANES-1:0]          feature_mask,
    input  logic [LANES*WORD_W-1:0]   feature_value,
    input  logic [LANES*COL_W-1:0]    feature_rows,
    input  logic [LANES*COL_W-1:0]    feature_cols,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          data_out,
    output logic [COL_W-1:0]          out_row,
    output logic [COL_W-1:0]          out_col,
    output logic                      busy
);

    localparam int OUT  = IMAGE - KERNEL + 1;
    localparam int NPIX = OUT * OUT;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = 2 * WORD_W;

    localparam logic [COL_W:0]   OUT_R      = (COL_W+1)'(OUT);
    localparam logic [AW-1:0]    OUT_A      = AW'(OUT);
    localparam logic [AW-1:0]    LAST_ADDR  = AW'(NPIX - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(OUT - 1);

    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

    state_t state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [COL_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    logic [LANES-1:0]        s1_vld_q, s1_vld_d;
    logic signed [PW-1:0]    s1_prod_q [LANES];
    logic signed [PW-1:0]    s1_prod_d [LANES];
    logic [AW-1:0]           s1_addr_q [LANES];
    logic [AW-1:0]           s1_addr_d [LANES];
    logic [COL_W:0]          dr [LANES];
    logic [COL_W:0]          dc [LANES];

    logic signed [ACC_W-1:0] acc_q [NPIX];
    logic signed [ACC_W-1:0] acc_sum [LANES];

    logic accept;
    logic drain_hs;

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign accept    = in_valid && in_ready;
    assign drain_hs  = out_valid && out_ready;
    assign data_out  = out_valid ? acc_q[addr_q] : '0;
    assign out_row   = row_q;
    assign out_col   = col_q;

    // Stage 1 combinational: per-lane product, output coordinate, range check and flat address.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            // Zero-extended operands make a negative difference show up in the top bit.
            dr[i] = {1'b0, feature_rows[i*COL_W +: COL_W]} - {1'b0, weight_rows};
            dc[i] = {1'b0, feature_cols[i*COL_W +: COL_W]} - {1'b0, weight_cols};
            s1_prod_d[i] = $signed(weight_value) * $signed(feature_value[i*WORD_W +: WORD_W]);
            s1_addr_d[i] = AW'(dr[i][COL_W-1:0]) * OUT_A + AW'(dc[i][COL_W-1:0]);
            s1_vld_d[i]  = accept && feature_mask[i]
                           && !dr[i][COL_W] && (dr[i] < OUT_R)
                           && !dc[i][COL_W] && (dc[i] < OUT_R);
        end
    end

    // Stage 1 register: lanes that survived the mask and range check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
                s1_addr_q[i] <= '0;
            end
        end else begin
            s1_vld_q <= s1_vld_d;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= s1_prod_d[i];
                s1_addr_q[i] <= s1_addr_d[i];
            end
        end
    end

    // Stage 2 adder per lane: read the addressed accumulator and add the sign-extended product.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            logic signed [ACC_W-1:0] p_ext;
            logic signed [ACC_W-1:0] cur;
            p_ext = ACC_W'(s1_prod_q[i]);
            cur   = acc_q[s1_addr_q[i]];
`ifdef SPE_SATURATE_EN
            begin
                logic [ACC_W:0] wide;
                wide = {cur[ACC_W-1], cur} + {p_ext[ACC_W-1], p_ext};
                if (wide[ACC_W] != wide[ACC_W-1])
                    acc_sum[i] = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
                else
                    acc_sum[i] = wide[ACC_W-1:0];
            end
`else
            acc_sum[i] = cur + p_ext;
`endif
        end
    end

    // Accumulator plane: lanes never collide within a beat, drain clears each pixel as it leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NPIX; k++) acc_q[k] <= '0;
        end else begin
            if (drain_hs) acc_q[addr_q] <= '0;
            for (int i = 0; i < LANES; i++) begin
                if (s1_vld_q[i]) acc_q[s1_addr_q[i]] <= acc_sum[i];
            end
        end
    end

    // Control state and drain counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next state: one FLUSH cycle lets the last beat commit before the raster drain begins.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ACCUM: if (accept && in_last) state_d = FLUSH;
            FLUSH: state_d = DRAIN;
            DRAIN: begin
                if (out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

endmodule
